mem_lsu_stage: RTL and testbench
================================

// Module: mem_lsu_stage
// PURPOSE
//  Parametrised memory-access pipeline stage between EXE and WB. Adds a req/gnt + rvalid
//  data-memory handshake (variable latency), full valid/allow_in flow control, flush with
//  response draining, and DATA_W of 32 or 64 (doubleword ld/sd at 64). Non-memory ops pass through.
// PARAMETERS
//  DATA_W  32  data/address width; 32 or 64 only (elaboration error otherwise)
//  PASS_W  96  width of opaque sideband carried EXE->WB (rf_wen, wdest, pc, hi/lo, cp0 ctl)
//  BE_W    DATA_W/8  byte-enable width (derived, do not override)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  flush        in   1       kill the instruction held in the stage
//  exe_valid    in   1       EXE presents an instruction
//  mem_allow_in out  1       stage accepts exe_* this cycle
//  exe_load     in   1       load op
//  exe_store    in   1       store op (load&store both 1 = illegal, treated as load)
//  exe_size     in   2       00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//  exe_signed   in   1       sign-extend load result
//  exe_result   in   DATA_W  ALU result; effective address for load/store
//  exe_wdata    in   DATA_W  store data, right-aligned
//  exe_pass     in   PASS_W  sideband, forwarded unchanged
//  dm_req       out  1       memory request valid
//  dm_gnt       in   1       memory accepts request
//  dm_we        out  BE_W    byte write enables (0 = read)
//  dm_addr      out  DATA_W  address, low log2(BE_W) bits forced to 0
//  dm_wdata     out  DATA_W  lane-shifted store data
//  dm_rvalid    in   1       read data valid (one per granted load, in order)
//  dm_rdata     in   DATA_W  read data
//  wb_valid     out  1       result valid to WB
//  wb_allow_in  in   1       WB accepts this cycle
//  wb_result    out  DATA_W  load data (extended) or exe_result or bad vaddr
//  wb_pass      out  PASS_W  forwarded sideband
//  wb_exc       out  2       00 none, 01 ADEL, 10 ADES
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; stage regs cleared; reset mid-transaction abandons it.
//  Accept when exe_valid && mem_allow_in; inputs registered; first memory action next cycle.
//  mem_allow_in = (state==IDLE) || (state==DONE && wb_allow_in && !flush).
//  FSM: IDLE -> REQ (load/store) | DONE (other op, 1-cycle latency).
//   REQ:  dm_req=1, address/we/wdata stable until dm_gnt. gnt&store -> DONE; gnt&load -> RESP.
//         gnt and rvalid in same cycle allowed (zero-wait memory): load goes straight to DONE.
//   RESP: wait dm_rvalid; capture extracted/extended data -> DONE.
//   DONE: wb_valid=1, outputs held; wb_allow_in -> IDLE, or accept next op in same cycle.
//   DRAIN: load granted but response not yet returned when flushed; swallow one rvalid -> IDLE.
//  Flush: IDLE/DONE -> IDLE; REQ -> request still held until gnt (no retraction), then store
//   write stands, load -> DRAIN; RESP -> DRAIN. mem_allow_in=0 while in DRAIN.
//  Lanes: sel = addr[log2(BE_W)-1:0]; byte we=1<<sel, half 2'b11<<sel, word 4'hF<<sel,
//   dword all ones; wdata replicated into the selected lane. Load extracts same lane,
//   zero- or sign-extends from the size MSB to DATA_W.
//  wb_result for non-memory op = exe_result; wb_valid never asserted for flushed op.
// CONFIGURATION
//  LSU_ALIGN_EXC_EN defined: addr not multiple of size -> no dm_req, state -> DONE with
//   wb_exc=ADEL (load)/ADES (store), wb_result = faulting address.
//  Not defined: wb_exc tied 00; misaligned addr low bits below size cleared before lane select.
// STRUCTURE
//  lsu_pkg: size encodings, exc codes, state enum {IDLE,REQ,RESP,DONE,DRAIN}, lane helpers.
//  Sub-module lsu_lane_align (combinational): we/wdata generation and load extract/extend.
// TESTING
//  1 DATA_W=32, sw 0xDEADBEEF @0x100, gnt after 3 cyc -> dm_we=1111 held 3 cyc, wb_valid next cycle.
//  2 lb signed @0x103, rdata 0x80AABBCC, rvalid 2 cyc after gnt -> wb_result 0xFFFFFF80; lbu -> 0x80.
//  3 sh 0x1234 @0x102 -> dm_we=1100, dm_wdata 0x1234xxxx; DATA_W=64 sd -> dm_we=0xFF.
//  4 lw issued, flush in RESP, next op accepted only after swallowed rvalid; no wb_valid for lw.
//  5 back-to-back adds with wb_allow_in held 0 for 4 cyc -> outputs stable, mem_allow_in=0, no loss.
//  6 LSU_ALIGN_EXC_EN: lw @0x102 -> dm_req never 1, wb_exc=01, wb_result 0x102; undefined -> reads 0x100.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-access stage: access sizes, exception codes,
// FSM states and the small lane helpers used by the stage and its lane aligner.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    DRAIN
  } lsu_state_e;

  // Address bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // A doubleword request on a 32-bit datapath degrades to a word access.
  function automatic logic [1:0] clamp_size(input logic [1:0] size, input logic wide);
    return (!wide && size == SZ_DWORD) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_lsu_stage_if.sv
// Data-memory port of the memory-access stage. master = LSU side, slave = memory side.
interface mem_lsu_stage_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // dm_req stays high with dm_addr/dm_we/dm_wdata stable until a cycle with
  // dm_gnt=1 (transfer); each granted read returns exactly one dm_rvalid, in
  // order, possibly in the grant cycle itself.
  logic              dm_req;
  logic              dm_gnt;
  logic [BE_W-1:0]   dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load lane extraction with zero/sign extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int SEL_W  = $clog2(BE_W)
) (
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   we,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] sh;

  assign sh = rdata >> {sel, 3'b000};

  // Size casts of a $signed operand sign-extend, which keeps the word case
  // legal on a 32-bit datapath where no extension bits exist.
  always_comb begin
    we         = '0;
    lane_wdata = '0;
    load_data  = '0;
    case (size)
      SZ_BYTE: begin
        we         = BE_W'(1) << sel;
        lane_wdata = {BE_W{wdata[7:0]}};
        load_data  = sgn ? DATA_W'($signed(sh[7:0])) : DATA_W'(sh[7:0]);
      end
      SZ_HALF: begin
        we         = BE_W'(2'b11) << sel;
        lane_wdata = {(DATA_W/16){wdata[15:0]}};
        load_data  = sgn ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]);
      end
      SZ_WORD: begin
        we         = BE_W'(4'hF) << sel;
        lane_wdata = {(DATA_W/32){wdata[31:0]}};
        load_data  = sgn ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0]);
      end
      default: begin
        we         = '1;
        lane_wdata = wdata;
        load_data  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// EXE->WB memory-access stage with req/gnt + rvalid data memory, flush with response
// draining. Optional LSU_ALIGN_EXC_EN: misaligned accesses raise ADEL/ADES instead of issuing.
module mem_lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PASS_W = 96,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              exe_valid,
  output logic              mem_allow_in,
  input  logic              exe_load,
  input  logic              exe_store,
  input  logic [1:0]        exe_size,
  input  logic              exe_signed,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [DATA_W-1:0] exe_wdata,
  input  logic [PASS_W-1:0] exe_pass,
  mem_lsu_stage_if.master   dm,
  output logic              wb_valid,
  input  logic              wb_allow_in,
  output logic [DATA_W-1:0] wb_result,
  output logic [PASS_W-1:0] wb_pass,
  output logic [1:0]        wb_exc,
  output lsu_state_e        dbg_state
);

  localparam int SEL_W = $clog2(BE_W);

  if (!(DATA_W == 32 || DATA_W == 64) || BE_W != DATA_W / 8) begin : g_bad_cfg
    $error("mem_lsu_stage: DATA_W must be 32 or 64 and BE_W must equal DATA_W/8");
  end

  lsu_state_e        state;
  logic              st_q, sgn_q, kill_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] addr_q, wdata_q, res_q;
  logic [PASS_W-1:0] pass_q;

  logic              accept, is_mem, kill_now, take_exc;
  logic [1:0]        eff_size;
  logic [2:0]        low_mask;
  logic [BE_W-1:0]   lane_we;
  logic [DATA_W-1:0] lane_wdata, load_data;

  assign eff_size     = clamp_size(exe_size, DATA_W == 64);
  assign low_mask     = size_mask(eff_size);
  assign is_mem       = exe_load | exe_store;
  assign mem_allow_in = (state == IDLE) || (state == DONE && wb_allow_in && !flush);
  assign accept       = exe_valid && mem_allow_in;
  assign kill_now     = kill_q | flush;

`ifdef LSU_ALIGN_EXC_EN
  logic [1:0] exc_q;
  assign take_exc = is_mem && (|(exe_result[2:0] & low_mask));
  assign wb_exc   = exc_q;
`else
  assign take_exc = 1'b0;
  assign wb_exc   = EXC_NONE;
`endif

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .SEL_W  (SEL_W)
  ) u_lane (
    .size       (size_q),
    .sgn        (sgn_q),
    .sel        (addr_q[SEL_W-1:0]),
    .wdata      (wdata_q),
    .rdata      (dm.dm_rdata),
    .we         (lane_we),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // kill_q remembers a flush that arrived while a request was still outstanding;
  // the request cannot be retracted, so its outcome is discarded later instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      st_q    <= 1'b0;
      sgn_q   <= 1'b0;
      kill_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      pass_q  <= '0;
`ifdef LSU_ALIGN_EXC_EN
      exc_q   <= EXC_NONE;
`endif
    end else begin
      case (state)
        REQ: begin
          if (flush) kill_q <= 1'b1;
          if (dm.dm_gnt) begin
            if (st_q) begin
              state <= kill_now ? IDLE : DONE;
            end else if (dm.dm_rvalid) begin
              if (!kill_now) res_q <= load_data;
              state <= kill_now ? IDLE : DONE;
            end else begin
              state <= kill_now ? DRAIN : RESP;
            end
          end
        end
        RESP: begin
          if (dm.dm_rvalid) begin
            if (!flush) res_q <= load_data;
            state <= flush ? IDLE : DONE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (flush || wb_allow_in) state <= IDLE;
        end
        DRAIN: begin
          if (dm.dm_rvalid) state <= IDLE;
        end
        default: ;
      endcase

      // A new op taken from IDLE or from DONE overrides the transition above.
      if (accept) begin
        st_q    <= exe_store & ~exe_load;
        sgn_q   <= exe_signed;
        size_q  <= eff_size;
        addr_q  <= exe_result & ~DATA_W'(low_mask);
        wdata_q <= exe_wdata;
        pass_q  <= exe_pass;
        res_q   <= exe_result;
        kill_q  <= 1'b0;
`ifdef LSU_ALIGN_EXC_EN
        exc_q   <= !take_exc ? EXC_NONE : (exe_load ? EXC_ADEL : EXC_ADES);
`endif
        state   <= (is_mem && !take_exc) ? REQ : DONE;
      end
    end
  end

  assign dm.dm_req   = (state == REQ);
  assign dm.dm_we    = (state == REQ && st_q) ? lane_we : '0;
  assign dm.dm_addr  = addr_q & ~DATA_W'(BE_W - 1);
  assign dm.dm_wdata = lane_wdata;

  assign wb_valid  = (state == DONE);
  assign wb_result = res_q;
  assign wb_pass   = pass_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: 32-bit instance for the main scenarios,
// 64-bit instance for doubleword lanes. Expected values are hand-computed.
module tb_mem_lsu_stage;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, exe_valid, mem_allow_in;
  logic        exe_load, exe_store, exe_signed;
  logic [1:0]  exe_size;
  logic [31:0] exe_result, exe_wdata;
  logic [95:0] exe_pass;
  logic        wb_valid, wb_allow_in;
  logic [31:0] wb_result;
  logic [95:0] wb_pass;
  logic [1:0]  wb_exc;
  lsu_state_e  dbg_state;

  logic        x_valid, x_allow_in, x_wb_valid;
  logic [63:0] x_result, x_wdata, x_wb_result;
  logic [7:0]  x_wb_pass;
  logic [1:0]  x_wb_exc;
  lsu_state_e  x_state;

  int n_tests = 0;
  int n_fail  = 0;

  mem_lsu_stage_if #(.DATA_W(32)) dm32 ();
  mem_lsu_stage_if #(.DATA_W(64)) dm64 ();

  mem_lsu_stage #(.DATA_W(32), .PASS_W(96)) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .exe_valid (exe_valid), .mem_allow_in (mem_allow_in),
    .exe_load (exe_load), .exe_store (exe_store), .exe_size (exe_size),
    .exe_signed (exe_signed), .exe_result (exe_result), .exe_wdata (exe_wdata),
    .exe_pass (exe_pass), .dm (dm32),
    .wb_valid (wb_valid), .wb_allow_in (wb_allow_in), .wb_result (wb_result),
    .wb_pass (wb_pass), .wb_exc (wb_exc), .dbg_state (dbg_state)
  );

  mem_lsu_stage #(.DATA_W(64), .PASS_W(8)) dut64 (
    .clk (clk), .reset (reset), .flush (flush),
    .exe_valid (x_valid), .mem_allow_in (x_allow_in),
    .exe_load (exe_load), .exe_store (exe_store), .exe_size (exe_size),
    .exe_signed (exe_signed), .exe_result (x_result), .exe_wdata (x_wdata),
    .exe_pass (8'h5A), .dm (dm64),
    .wb_valid (x_wb_valid), .wb_allow_in (wb_allow_in), .wb_result (x_wb_result),
    .wb_pass (x_wb_pass), .wb_exc (x_wb_exc), .dbg_state (x_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    exe_valid = 0; x_valid = 0; exe_load = 0; exe_store = 0; exe_size = 2'b00;
    exe_signed = 0; exe_result = '0; exe_wdata = '0; exe_pass = '0;
    x_result = '0; x_wdata = '0; flush = 0; wb_allow_in = 1;
    dm32.dm_gnt = 0; dm32.dm_rvalid = 0; dm32.dm_rdata = '0;
    dm64.dm_gnt = 0; dm64.dm_rvalid = 0; dm64.dm_rdata = '0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] res, input logic [31:0] wd, input logic [95:0] ps);
    exe_valid = 1; exe_load = ld; exe_store = st; exe_size = sz; exe_signed = sg;
    exe_result = res; exe_wdata = wd; exe_pass = ps;
  endtask

  task automatic test_reset();
    clr();
    reset = 1;
    tick(); tick();
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
    n_tests++; if (mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL rst_allow: got %b want 1", mem_allow_in); end
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    n_tests++; if (dm32.dm_req !== 1'b0 || dm32.dm_we !== 4'h0) begin n_fail++; $display("FAIL rst_dm: got req %b we %h want 0 0", dm32.dm_req, dm32.dm_we); end
    n_tests++; if (wb_result !== 32'h0 || wb_exc !== 2'b00) begin n_fail++; $display("FAIL rst_wb: got %h/%b want 0/00", wb_result, wb_exc); end
    reset = 0;
    tick();
  endtask

  task automatic test_store_word();
    drive(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 96'hA5);
    settle();
    n_tests++; if (mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL sw_allow: got %b want 1", mem_allow_in); end
    tick();
    exe_valid = 0;
    for (int i = 0; i < 3; i++) begin
      dm32.dm_gnt = (i == 2);
      settle();
      n_tests++; if (dm32.dm_req !== 1'b1 || dm32.dm_we !== 4'hF) begin n_fail++; $display("FAIL sw_req_c%0d: got req %b we %h want 1 f", i, dm32.dm_req, dm32.dm_we); end
      n_tests++; if (dm32.dm_addr !== 32'h100 || dm32.dm_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_bus_c%0d: got %h %h want 100 deadbeef", i, dm32.dm_addr, dm32.dm_wdata); end
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sw_early_wb: got %b want 0", wb_valid); end
      tick();
    end
    dm32.dm_gnt = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'h100) begin n_fail++; $display("FAIL sw_wb: got %b %h want 1 100", wb_valid, wb_result); end
    n_tests++; if (wb_pass !== 96'hA5 || dm32.dm_req !== 1'b0) begin n_fail++; $display("FAIL sw_pass: got %h req %b want a5 0", wb_pass, dm32.dm_req); end
    tick();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sw_retire: got %b want 0", wb_valid); end
  endtask

  task automatic load_case(input logic sg, input logic [31:0] exp);
    drive(1, 0, 2'b00, sg, 32'h103, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1;
    settle();
    n_tests++; if (dm32.dm_req !== 1'b1 || dm32.dm_we !== 4'h0 || dm32.dm_addr !== 32'h100) begin n_fail++; $display("FAIL lb_req: got %b %h %h want 1 0 100", dm32.dm_req, dm32.dm_we, dm32.dm_addr); end
    tick();
    dm32.dm_gnt = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b0 || dbg_state !== RESP) begin n_fail++; $display("FAIL lb_wait: got %b st %0d want 0 %0d", wb_valid, dbg_state, RESP); end
    tick();
    dm32.dm_rvalid = 1; dm32.dm_rdata = 32'h80AABBCC;
    tick();
    dm32.dm_rvalid = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== exp) begin n_fail++; $display("FAIL lb_data_s%0d: got %b %h want 1 %h", sg, wb_valid, wb_result, exp); end
    tick();
  endtask

  task automatic test_load();
    load_case(1'b1, 32'hFFFFFF80);
    load_case(1'b0, 32'h00000080);
    // Zero-wait memory: grant and data in the same cycle.
    drive(1, 0, 2'b01, 1, 32'h102, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1; dm32.dm_rvalid = 1; dm32.dm_rdata = 32'h80AABBCC;
    tick();
    dm32.dm_gnt = 0; dm32.dm_rvalid = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'hFFFF80AA) begin n_fail++; $display("FAIL lh_zero_wait: got %b %h want 1 ffff80aa", wb_valid, wb_result); end
    tick();
  endtask

  task automatic test_store_lanes();
    drive(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1;
    settle();
    n_tests++; if (dm32.dm_we !== 4'b1100 || dm32.dm_wdata[31:16] !== 16'h1234) begin n_fail++; $display("FAIL sh_lane: got %b %h want 1100 1234xxxx", dm32.dm_we, dm32.dm_wdata); end
    tick();
    dm32.dm_gnt = 0;
    tick();
    drive(0, 1, 2'b00, 0, 32'h101, 32'h000000AB, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1;
    settle();
    n_tests++; if (dm32.dm_we !== 4'b0010 || dm32.dm_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_lane: got %b %h want 0010 abababab", dm32.dm_we, dm32.dm_wdata); end
    tick();
    dm32.dm_gnt = 0;
    tick();
  endtask

  task automatic test_dword();
    exe_load = 0; exe_store = 1; exe_size = 2'b11; exe_signed = 0;
    x_valid = 1; x_result = 64'h1000; x_wdata = 64'h1122334455667788;
    tick();
    x_valid = 0;
    dm64.dm_gnt = 1;
    settle();
    n_tests++; if (dm64.dm_we !== 8'hFF || dm64.dm_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL sd_lane: got %h %h want ff 1122334455667788", dm64.dm_we, dm64.dm_wdata); end
    tick();
    dm64.dm_gnt = 0;
    settle();
    n_tests++; if (x_wb_valid !== 1'b1 || x_wb_pass !== 8'h5A) begin n_fail++; $display("FAIL sd_wb: got %b %h want 1 5a", x_wb_valid, x_wb_pass); end
    tick();
    exe_load = 1; exe_store = 0; exe_size = 2'b10; exe_signed = 1;
    x_valid = 1; x_result = 64'h1004;
    tick();
    x_valid = 0;
    dm64.dm_gnt = 1; dm64.dm_rvalid = 1; dm64.dm_rdata = 64'h80000000_00000000;
    settle();
    n_tests++; if (dm64.dm_addr !== 64'h1000) begin n_fail++; $display("FAIL lw64_addr: got %h want 1000", dm64.dm_addr); end
    tick();
    dm64.dm_gnt = 0; dm64.dm_rvalid = 0;
    settle();
    n_tests++; if (x_wb_result !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL lw64_data: got %h want ffffffff80000000", x_wb_result); end
    tick();
    clr();
  endtask

  task automatic test_flush();
    drive(1, 0, 2'b10, 0, 32'h200, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1;
    tick();
    dm32.dm_gnt = 0; flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 2'b10, 0, 32'h77, 32'h0, 96'h7);
    settle();
    n_tests++; if (mem_allow_in !== 1'b0 || dbg_state !== DRAIN) begin n_fail++; $display("FAIL fl_drain: got %b st %0d want 0 %0d", mem_allow_in, dbg_state, DRAIN); end
    tick();
    n_tests++; if (mem_allow_in !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_hold: got %b %b want 0 0", mem_allow_in, wb_valid); end
    dm32.dm_rvalid = 1; dm32.dm_rdata = 32'h12345678;
    settle();
    n_tests++; if (mem_allow_in !== 1'b0) begin n_fail++; $display("FAIL fl_swallow: got %b want 0", mem_allow_in); end
    tick();
    dm32.dm_rvalid = 0;
    settle();
    n_tests++; if (mem_allow_in !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_idle: got %b %b want 1 0", mem_allow_in, wb_valid); end
    tick();
    exe_valid = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'h77 || wb_pass !== 96'h7) begin n_fail++; $display("FAIL fl_next_op: got %b %h %h want 1 77 7", wb_valid, wb_result, wb_pass); end
    tick();
    // Store flushed while waiting for grant: request held, write stands, no WB.
    drive(0, 1, 2'b10, 0, 32'h300, 32'h55, 96'h0);
    tick();
    exe_valid = 0; flush = 1;
    tick();
    flush = 0; dm32.dm_gnt = 1;
    settle();
    n_tests++; if (dm32.dm_req !== 1'b1 || dm32.dm_we !== 4'hF) begin n_fail++; $display("FAIL fl_st_held: got %b %h want 1 f", dm32.dm_req, dm32.dm_we); end
    tick();
    dm32.dm_gnt = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL fl_st_nowb: got %b st %0d want 0 %0d", wb_valid, dbg_state, IDLE); end
    // Flush of a result waiting in DONE.
    wb_allow_in = 0;
    drive(0, 0, 2'b10, 0, 32'h99, 32'h0, 96'h0);
    tick();
    exe_valid = 0; flush = 1;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || mem_allow_in !== 1'b0) begin n_fail++; $display("FAIL fl_done: got %b %b want 1 0", wb_valid, mem_allow_in); end
    tick();
    flush = 0; wb_allow_in = 1;
    settle();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_done_kill: got %b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    wb_allow_in = 0;
    drive(0, 0, 2'b10, 0, 32'h11, 32'h0, 96'h1);
    tick();
    drive(0, 0, 2'b10, 0, 32'h22, 32'h0, 96'h2);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'h11 || wb_pass !== 96'h1 || mem_allow_in !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_c%0d: got %b %h %h %b want 1 11 1 0", i, wb_valid, wb_result, wb_pass, mem_allow_in); end
      tick();
    end
    wb_allow_in = 1;
    settle();
    n_tests++; if (mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL b2b_release: got %b want 1", mem_allow_in); end
    tick();
    drive(0, 0, 2'b10, 0, 32'h33, 32'h0, 96'h3);
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'h22 || wb_pass !== 96'h2) begin n_fail++; $display("FAIL b2b_second: got %b %h %h want 1 22 2", wb_valid, wb_result, wb_pass); end
    tick();
    exe_valid = 0;
    settle();
    n_tests++; if (wb_valid !== 1'b1 || wb_result !== 32'h33) begin n_fail++; $display("FAIL b2b_third: got %b %h want 1 33", wb_valid, wb_result); end
    tick();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_align();
`ifdef LSU_ALIGN_EXC_EN
    drive(1, 0, 2'b10, 0, 32'h102, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    settle();
    n_tests++; if (dm32.dm_req !== 1'b0 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL al_lw_noreq: got req %b wb %b want 0 1", dm32.dm_req, wb_valid); end
    n_tests++; if (wb_exc !== 2'b01 || wb_result !== 32'h102) begin n_fail++; $display("FAIL al_lw_exc: got %b %h want 01 102", wb_exc, wb_result); end
    tick();
    drive(0, 1, 2'b01, 0, 32'h101, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    settle();
    n_tests++; if (dm32.dm_req !== 1'b0 || wb_exc !== 2'b10 || wb_result !== 32'h101) begin n_fail++; $display("FAIL al_sh_exc: got %b %b %h want 0 10 101", dm32.dm_req, wb_exc, wb_result); end
    tick();
`else
    drive(1, 0, 2'b10, 0, 32'h102, 32'h0, 96'h0);
    tick();
    exe_valid = 0;
    dm32.dm_gnt = 1; dm32.dm_rvalid = 1; dm32.dm_rdata = 32'hCAFEF00D;
    settle();
    n_tests++; if (dm32.dm_req !== 1'b1 || dm32.dm_addr !== 32'h100) begin n_fail++; $display("FAIL al_lw_addr: got %b %h want 1 100", dm32.dm_req, dm32.dm_addr); end
    tick();
    dm32.dm_gnt = 0; dm32.dm_rvalid = 0;
    settle();
    n_tests++; if (wb_result !== 32'hCAFEF00D || wb_exc !== 2'b00) begin n_fail++; $display("FAIL al_lw_data: got %h %b want cafef00d 00", wb_result, wb_exc); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load();
    test_store_lanes();
    test_dword();
    test_flush();
    test_back_to_back();
    test_align();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
